// File: rtl/traffic_phase_ctrl.sv
// Traffic-intersection phase controller: round-robin or demand-actuated greens with
// yellow and all-red clearance, tick-based timing, and a flashing-yellow maintenance mode.
module traffic_phase_ctrl #(
   parameter int NUM_DIR  = 4,
   parameter int TICK_DIV = 50000000,
   parameter int GREEN_T  = 5,
   parameter int YELLOW_T = 1,
   parameter int ALLRED_T = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mode,
   input  logic                   flash_req,
   input  logic [NUM_DIR-1:0]     car_present,
   output logic [2*NUM_DIR-1:0]   lights,
   output logic [2:0]             active_dir,
   output logic [1:0]             phase,
   output logic                   tick
);

   localparam int MAX_T = (GREEN_T > YELLOW_T) ? ((GREEN_T > ALLRED_T) ? GREEN_T : ALLRED_T)
                                               : ((YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T);
   localparam int TW = $clog2(MAX_T + 1);
   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

   typedef enum logic [1:0] {
      ALLRED = 2'b00,
      GREEN  = 2'b01,
      YELLOW = 2'b10,
      FLASH  = 2'b11
   } state_t;

   state_t             state_reg;
   logic [2:0]         dir_reg;
   logic [PW-1:0]      presc_reg;
   logic [TW-1:0]      timer_reg;
   logic [NUM_DIR-1:0] demand_reg;
   logic               blink_reg;

   logic [TW-1:0]      last_count;
   logic               last_tick;
   logic               enter_green;
   logic [2:0]         next_dir;
   logic [DW-1:0]      cand;
   logic               found;
   logic [NUM_DIR-1:0] others;
   logic [NUM_DIR-1:0] demand_next;

   assign tick       = (presc_reg == PW'(TICK_DIV - 1));
   assign phase      = state_reg;
   assign active_dir = dir_reg;

   always_comb begin
      case (state_reg)
         GREEN:   last_count = TW'(GREEN_T - 1);
         YELLOW:  last_count = TW'(YELLOW_T - 1);
         default: last_count = TW'(ALLRED_T - 1);
      endcase
   end

   assign last_tick   = tick && (timer_reg == last_count);
   assign others      = demand_reg & ~(NUM_DIR'(1) << dir_reg);
   assign enter_green = !flash_req && (state_reg == ALLRED) && last_tick;
   assign demand_next = enter_green ? ((demand_reg | car_present) & ~(NUM_DIR'(1) << next_dir))
                                    : (demand_reg | car_present);

   // Actuated selection scans round-robin from the direction after the current one.
   always_comb begin
      next_dir = 3'((int'(dir_reg) + 1) % NUM_DIR);
      found    = 1'b0;
      cand     = '0;
      if (mode) begin
         for (int k = 1; k <= NUM_DIR; k++) begin
            cand = DW'((int'(dir_reg) + k) % NUM_DIR);
            if (!found && demand_reg[cand]) begin
               next_dir = 3'(cand);
               found    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ALLRED;
         dir_reg    <= 3'(NUM_DIR - 1);
         presc_reg  <= '0;
         timer_reg  <= '0;
         demand_reg <= '0;
         blink_reg  <= 1'b0;
      end else begin
         presc_reg  <= tick ? '0 : presc_reg + PW'(1);
         demand_reg <= demand_next;
         if (flash_req) begin
            if (state_reg != FLASH) begin
               state_reg <= FLASH;
               blink_reg <= 1'b1;
               timer_reg <= '0;
            end else if (tick) begin
               blink_reg <= ~blink_reg;
            end
         end else if (state_reg == FLASH) begin
            // Leaving maintenance: full clearance, then direction 0 gets the first green.
            state_reg <= ALLRED;
            timer_reg <= '0;
            dir_reg   <= 3'(NUM_DIR - 1);
         end else if (tick) begin
            if (timer_reg == last_count) begin
               timer_reg <= '0;
               case (state_reg)
                  GREEN:   if (!(mode && (others == '0))) state_reg <= YELLOW;
                  YELLOW:  state_reg <= ALLRED;
                  default: begin
                     state_reg <= GREEN;
                     dir_reg   <= next_dir;
                  end
               endcase
            end else begin
               timer_reg <= timer_reg + TW'(1);
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
         assign lights[2*gi+1:2*gi] =
            (state_reg == FLASH) ? {1'b0, blink_reg} :
            (dir_reg == 3'(gi))  ? ((state_reg == GREEN)  ? 2'b10 :
                                    (state_reg == YELLOW) ? 2'b01 : 2'b00) :
                                   2'b00;
      end
   endgenerate

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: a tick-counting reference model queues the
// expected outputs per cycle and an independent monitor compares them against the DUT.
module tb_traffic_phase_ctrl;

   localparam int ND = 4;
   localparam int TD = 4;
   localparam int GT = 3;
   localparam int YT = 1;
   localparam int AT = 1;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         mode = 1'b0;
   logic         flash_req = 1'b0;
   logic [ND-1:0] car_present = '0;
   logic [2*ND-1:0] lights;
   logic [2:0]   active_dir;
   logic [1:0]   phase;
   logic         tick;

   always #5 clk = ~clk;

   traffic_phase_ctrl #(
      .NUM_DIR (ND),
      .TICK_DIV(TD),
      .GREEN_T (GT),
      .YELLOW_T(YT),
      .ALLRED_T(AT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mode       (mode),
      .flash_req  (flash_req),
      .car_present(car_present),
      .lights     (lights),
      .active_dir (active_dir),
      .phase      (phase),
      .tick       (tick)
   );

   typedef struct packed {
      logic [2*ND-1:0] lights;
      logic [1:0]      phase;
      logic [2:0]      dir;
      logic            tick;
      logic            in_reset;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int errors = 0;

   // Reference model: phase 0=allred 1=green 2=yellow 3=flash, ticks left in the phase,
   // and cycles elapsed since reset release (tick falls on every TD-th cycle).
   int m_ph, m_dir, m_left, m_cyc;
   logic [ND-1:0] m_dem;
   logic m_blink;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ph = 0; m_dir = ND - 1; m_left = AT; m_cyc = 0; m_dem = '0; m_blink = 1'b0;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e = '0;
      for (int d = 0; d < ND; d++) begin
         logic [1:0] code;
         code = 2'b00;
         if (m_ph == 3) code = m_blink ? 2'b01 : 2'b00;
         else if (d == m_dir && m_ph == 1) code = 2'b10;
         else if (d == m_dir && m_ph == 2) code = 2'b01;
         e.lights[2*d +: 2] = code;
      end
      e.phase = 2'(m_ph);
      e.dir = 3'(m_dir);
      e.tick = ((m_cyc % TD) == TD - 1);
      e.in_reset = reset;
      return e;
   endfunction

   task automatic model_step(input logic m, input logic f, input logic [ND-1:0] c);
      logic tk;
      logic [ND-1:0] dem_old, dem_new;
      int entered, nd;
      tk = ((m_cyc % TD) == TD - 1);
      dem_old = m_dem;
      dem_new = m_dem | c;
      entered = -1;
      if (f) begin
         if (m_ph != 3) begin m_ph = 3; m_blink = 1'b1; end
         else if (tk) m_blink = ~m_blink;
      end else if (m_ph == 3) begin
         m_ph = 0; m_left = AT; m_dir = ND - 1;
      end else if (tk) begin
         m_left--;
         if (m_left == 0) begin
            if (m_ph == 1) begin
               int oth;
               oth = 0;
               for (int d = 0; d < ND; d++) if (d != m_dir && dem_old[d]) oth++;
               if (m && oth == 0) m_left = GT;
               else begin m_ph = 2; m_left = YT; end
            end else if (m_ph == 2) begin
               m_ph = 0; m_left = AT;
            end else begin
               nd = (m_dir + 1) % ND;
               if (m) begin
                  for (int k = ND; k >= 1; k--)
                     if (dem_old[(m_dir + k) % ND]) nd = (m_dir + k) % ND;
               end
               m_dir = nd; m_ph = 1; m_left = GT; entered = nd;
            end
         end
      end
      if (entered >= 0) dem_new[entered] = 1'b0;
      m_dem = dem_new;
      m_cyc++;
   endtask

   task automatic hold_cycle();
      @(negedge clk);
      sbq.push_back(model_out());
   endtask

   task automatic cycle(input logic m, input logic f, input logic [ND-1:0] c);
      @(negedge clk);
      sbq.push_back(model_out());
      reset = 1'b0;
      mode = m; flash_req = f; car_present = c;
      model_step(m, f, c);
   endtask

   task automatic async_reset();
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_lights", int'(lights), 0);
      chk("async_rst_phase", int'(phase), 0);
      chk("async_rst_dir", int'(active_dir), ND - 1);
      chk("async_rst_tick", int'(tick), 0);
      model_reset();
      repeat (3) hold_cycle();
   endtask

   // Monitor: one comparison set per cycle, plus safety and tick-shape checks.
   initial begin
      exp_t e;
      int mon_cyc, last_tick;
      logic prev_tick;
      int nonred;
      mon_cyc = 0; last_tick = -1; prev_tick = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         mon_cyc++;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("lights", int'(lights), int'(e.lights));
            chk("phase", int'(phase), int'(e.phase));
            chk("active_dir", int'(active_dir), int'(e.dir));
            chk("tick", int'(tick), int'(e.tick));
            if (e.in_reset) begin
               last_tick = -1; prev_tick = 1'b0;
            end else begin
               if (tick) begin
                  chk("tick_width", int'(prev_tick), 0);
                  if (last_tick >= 0) chk("tick_period", mon_cyc - last_tick, TD);
                  last_tick = mon_cyc;
               end
               prev_tick = tick;
            end
         end
         if (phase != 2'b11) begin
            nonred = 0;
            for (int d = 0; d < ND; d++) if (lights[2*d +: 2] != 2'b00) nonred++;
            chk("one_non_red", int'(nonred <= 1), 1);
         end
      end
   end

   task automatic wait_model(input int ph, input int dir, input logic m, input string name);
      int n;
      n = 0;
      while (!(m_ph == ph && (dir < 0 || m_dir == dir)) && n < 200) begin
         cycle(m, 1'b0, '0);
         n++;
      end
      chk(name, int'(m_ph == ph && (dir < 0 || m_dir == dir)), 1);
   endtask

   initial begin
      logic rm, rf;
      logic [ND-1:0] rc;
      model_reset();
      repeat (3) hold_cycle();

      // Fixed rotation with no traffic, slightly more than one full period.
      repeat (90) cycle(1'b0, 1'b0, '0);
      $display("fixed rotation done, model dir %0d phase %0d", m_dir, m_ph);

      // Actuated: demand on dir 1 during dir-0 green, extension, then dir 3 skipping dir 2.
      async_reset();
      wait_model(1, 0, 1'b1, "wait_dir0_green");
      repeat (10) cycle(1'b1, 1'b0, '0);
      cycle(1'b1, 1'b0, 4'b0010);
      repeat (50) cycle(1'b1, 1'b0, '0);
      cycle(1'b1, 1'b0, 4'b1000);
      repeat (40) cycle(1'b1, 1'b0, '0);
      $display("actuated sequence done, model dir %0d phase %0d", m_dir, m_ph);

      // Flash entered mid-green, then released into clearance.
      wait_model(1, -1, 1'b0, "wait_green_for_flash");
      cycle(1'b0, 1'b0, '0);
      repeat (18) cycle(1'b0, 1'b1, '0);
      repeat (30) cycle(1'b0, 1'b0, '0);
      $display("flash sequence done, model dir %0d phase %0d", m_dir, m_ph);

      // Reset pulsed in the middle of a yellow.
      wait_model(2, -1, 1'b0, "wait_yellow");
      async_reset();
      repeat (30) cycle(1'b0, 1'b0, '0);
      $display("mid-yellow reset done, model dir %0d phase %0d", m_dir, m_ph);

      // Randomized traffic, mode and maintenance requests.
      rm = 1'b0; rf = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) rm = ~rm;
         if (!rf && $urandom_range(0, 299) == 0) rf = 1'b1;
         else if (rf && $urandom_range(0, 15) == 0) rf = 1'b0;
         rc = ($urandom_range(0, 9) == 0) ? ND'($urandom) : '0;
         cycle(rm, rf, rc);
         if (i == 1500) async_reset();
      end
      $display("random phase done, model dir %0d phase %0d", m_dir, m_ph);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
